// File: rtl/fetch_decode_queue_pkg.sv
// fetch_decode_queue_pkg: shared types and sizing for the fetch-to-decode instruction queue.
// Ports: none (package). Exports fdq_entry_t, default sizes and the misalignment helper.
package fetch_decode_queue_pkg;
    localparam int FDQ_XLEN  = 32;
    localparam int FDQ_DEPTH = 4;
    localparam int FDQ_PTR_W = $clog2(FDQ_DEPTH);

    typedef struct packed {
        logic [FDQ_XLEN-1:0] pc;
        logic [FDQ_XLEN-1:0] instr;
        logic                misalign;
    } fdq_entry_t;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction
endpackage

// File: rtl/fdq_if.sv
// fdq_if: fetch-side and decode-side handshake bundle of the fetch decode queue.
// Ports: fetch pair (f_valid, f_pc, f_instr) with f_stall backpressure, flush redirect,
//        decode head (d_valid, d_pc, d_instr, d_misalign) with d_ready, occupancy count.
//        master = fetch/decode environment, slave = the queue.
interface fdq_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                       f_valid;
    logic [XLEN-1:0]            f_pc;
    logic [XLEN-1:0]            f_instr;
    logic                       f_stall;
    logic                       flush;
    logic                       d_valid;
    logic [XLEN-1:0]            d_pc;
    logic [XLEN-1:0]            d_instr;
    logic                       d_misalign;
    logic                       d_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output f_valid, f_pc, f_instr, flush, d_ready,
        input  f_stall, d_valid, d_pc, d_instr, d_misalign, count
    );

    modport slave (
        input  f_valid, f_pc, f_instr, flush, d_ready,
        output f_stall, d_valid, d_pc, d_instr, d_misalign, count
    );
endinterface

// File: rtl/fdq_ptr.sv
// fdq_ptr: wrapping queue pointer for arbitrary (non power-of-two) depths.
// Ports: clk, reset (sync, active-high), inc advances, clr returns to 0, ptr current value.
module fdq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int W = $clog2(DEPTH);

    // Explicit compare against the last slot so any depth wraps correctly.
    always_ff @(posedge clk) begin
        if (reset || clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);
    end
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: FIFO of fetched {pc, instr} pairs ahead of decode, flushed on redirect.
// Ports: clk, reset (sync, active-high), bus (fdq_if.slave): fetch pair in with f_stall
//        backpressure, flush, head entry out to decode with d_ready, registered count.
//        XLEN must match the package entry width.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int DEPTH = FDQ_DEPTH,
    parameter int XLEN  = FDQ_XLEN
) (
    input  logic  clk,
    input  logic  reset,
    fdq_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            full;
    logic            push;
    logic            pop;
    fdq_entry_t      mem [DEPTH];
    fdq_entry_t      head_e;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;

    // Stall depends only on registered occupancy: a full queue never accepts in the
    // same cycle it pops, which keeps d_ready off the fetch timing path.
    assign full    = count == CW'(DEPTH);
    assign push    = bus.f_valid && !full && !bus.flush;
    assign pop     = bus.d_valid && bus.d_ready;

    assign bus.f_stall = full;
    assign bus.d_valid = (count != '0) && !bus.flush;
    assign bus.count   = count;

    assign head_e     = mem[head];
    assign head_pc    = bus.d_valid ? head_e.pc : '0;
    assign head_instr = bus.d_valid ? head_e.instr : '0;

    assign bus.d_pc       = head_pc;
    assign bus.d_instr    = head_instr;
    assign bus.d_misalign = bus.d_valid && head_e.misalign;

    fdq_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clr   (bus.flush),
        .ptr   (head)
    );

    fdq_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .clr   (bus.flush),
        .ptr   (tail)
    );

    // Storage is deliberately not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{pc: bus.f_pc, instr: bus.f_instr, misalign: is_misaligned(bus.f_pc[1:0])};
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush)
            count <= '0;
        else
            count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed table, corner sequences and random traffic against a queue model.
// Ports: none (top-level bench).
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fdq_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        dr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_st;
    } vec_t;

    pair_t q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] ins(input logic [31:0] p);
        return 32'h13 | (p << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic fl, input logic dr);
        reset       = r;
        bus.f_valid = fv;
        bus.f_pc    = pc;
        bus.f_instr = instr;
        bus.flush   = fl;
        bus.d_ready = dr;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic dv;
        dv = (q.size() != 0) && !bus.flush;
        chk({tag, ".d_valid"}, 32'(bus.d_valid), 32'(dv));
        chk({tag, ".d_pc"}, bus.d_pc, dv ? q[0].pc : 32'h0);
        chk({tag, ".d_instr"}, bus.d_instr, dv ? q[0].instr : 32'h0);
        chk({tag, ".d_misalign"}, 32'(bus.d_misalign), 32'(dv && (q[0].pc % 4 != 0)));
        chk({tag, ".count"}, 32'(bus.count), q.size());
        chk({tag, ".f_stall"}, 32'(bus.f_stall), 32'(q.size() == DEPTH));
    endtask

    // Model: a plain queue; pops the front when decode takes it, appends when fetch is not stalled.
    task automatic advance();
        logic dv;
        logic st;
        dv = (q.size() != 0) && !bus.flush;
        st = q.size() == DEPTH;
        @(posedge clk);
        if (reset || bus.flush)
            q.delete();
        else begin
            if (dv && bus.d_ready)
                void'(q.pop_front());
            if (bus.f_valid && !st)
                q.push_back('{bus.f_pc, bus.f_instr});
        end
        @(negedge clk);
    endtask

    vec_t tbl[15];

    initial begin
        logic [31:0] rp;
        logic [31:0] ri;
        tbl = '{
            '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0},
            '{1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0},
            '{1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 3'd1, 1'b0},
            '{1'b1, 32'h04, 1'b0, 1'b1, 32'h00, 3'd1, 1'b0},
            '{1'b1, 32'h08, 1'b0, 1'b1, 32'h00, 3'd2, 1'b0},
            '{1'b1, 32'h0C, 1'b0, 1'b1, 32'h00, 3'd3, 1'b0},
            '{1'b1, 32'h10, 1'b0, 1'b1, 32'h00, 3'd4, 1'b1},
            '{1'b1, 32'h10, 1'b0, 1'b1, 32'h00, 3'd4, 1'b1},
            '{1'b1, 32'h10, 1'b1, 1'b1, 32'h00, 3'd4, 1'b1},
            '{1'b1, 32'h10, 1'b1, 1'b1, 32'h04, 3'd3, 1'b0},
            '{1'b0, 32'h00, 1'b0, 1'b1, 32'h08, 3'd3, 1'b0},
            '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 3'd3, 1'b0},
            '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 3'd2, 1'b0},
            '{1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 3'd1, 1'b0},
            '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0}
        };
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            advance();
        end

        // Reset state, first push latency, fill to full, held pair, pop while full.
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, tbl[i].fv, tbl[i].pc, ins(tbl[i].pc), 1'b0, tbl[i].dr);
            chk($sformatf("tbl%0d.d_valid", i), 32'(bus.d_valid), 32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d.d_pc", i), bus.d_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.d_instr", i), bus.d_instr, tbl[i].e_dv ? ins(tbl[i].e_pc) : 32'h0);
            chk($sformatf("tbl%0d.d_misalign", i), 32'(bus.d_misalign), 32'h0);
            chk($sformatf("tbl%0d.count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.f_stall", i), 32'(bus.f_stall), 32'(tbl[i].e_st));
            advance();
        end

        // Steady push/pop at count=2 across pointer wrap.
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b1, 32'h0, ins(32'h0), 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b1, 32'h4, ins(32'h4), 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 32'(8 + 4 * k), ins(32'(8 + 4 * k)), 1'b0, 1'b1);
            chk($sformatf("stream%0d.count", k), 32'(bus.count), 32'd2);
            chk($sformatf("stream%0d.d_pc", k), bus.d_pc, 32'(4 * k));
            advance();
        end

        // Flush at count=3 drops queue and the flush-cycle pair.
        drive(1'b0, 1'b1, 32'h30, ins(32'h30), 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b1, 32'h40, ins(32'h40), 1'b1, 1'b1);
        chk("flush.d_valid", 32'(bus.d_valid), 32'h0);
        chk("flush.count_pre", 32'(bus.count), 32'd3);
        chk("flush.f_stall", 32'(bus.f_stall), 32'h0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_flush.count", 32'(bus.count), 32'h0);
        chk("post_flush.d_valid", 32'(bus.d_valid), 32'h0);
        drive(1'b0, 1'b1, 32'h80, ins(32'h80), 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("after_flush.d_pc", bus.d_pc, 32'h80);
        chk("after_flush.d_valid", 32'(bus.d_valid), 32'h1);

        // Misaligned head, then reset mid-stream at count=3.
        drive(1'b0, 1'b1, 32'h102, ins(32'h102), 1'b0, 1'b1);
        advance();
        drive(1'b0, 1'b1, 32'h104, ins(32'h104), 1'b0, 1'b0);
        chk("misalign.d_pc", bus.d_pc, 32'h102);
        chk("misalign.flag", 32'(bus.d_misalign), 32'h1);
        advance();
        drive(1'b0, 1'b1, 32'h108, ins(32'h108), 1'b0, 1'b0);
        advance();
        drive(1'b1, 1'b1, 32'h10C, ins(32'h10C), 1'b1, 1'b0);
        chk("pre_reset.count", 32'(bus.count), 32'd3);
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_reset.count", 32'(bus.count), 32'h0);
        chk("post_reset.d_valid", 32'(bus.d_valid), 32'h0);
        chk("post_reset.d_pc", bus.d_pc, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            rp = $urandom();
            ri = $urandom();
            if ($urandom_range(0, 7) != 0)
                rp = rp & 32'hFFFF_FFFC;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rp, ri,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            check_model($sformatf("rnd%0d", n));
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
